// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store sequencer with sub-word read-modify-write over a word-only bus
module lsu_ctrl #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [3:0]            mem_op_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  output logic                  stall_o,
  output logic [DATA_WIDTH-1:0] reg_wdata_o,
  output logic                  reg_we_o,
  output logic                  misalign_o,
  output logic                  bus_err_o,
  output logic                  bus_req_o,
  output logic                  bus_we_o,
  output logic [ADDR_WIDTH-1:0] bus_addr_o,
  output logic [DATA_WIDTH-1:0] bus_wdata_o,
  input  logic [DATA_WIDTH-1:0] bus_rdata_i,
  input  logic                  bus_ack_i
);

  localparam logic [3:0] MEM_NOP = 4'd0, LB = 4'd1, LH = 4'd2, LW = 4'd3, LBU = 4'd4,
                         LHU = 4'd5, SB = 4'd6, SH = 4'd7, SW = 4'd8;
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_DONE, S_ERR} state_t;

  state_t                state;
  logic [3:0]            op_q;
  logic [1:0]            lane_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [31:0]           timer;
  logic                  op_valid;
  logic                  op_misal;
  logic                  op_q_load;
  logic                  timeout_hit;

  function automatic logic [DATA_WIDTH-1:0] extract(input logic [3:0] op,
                                                    input logic [DATA_WIDTH-1:0] word,
                                                    input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {lane, 3'b000});
    h = lane[1] ? word[31:16] : word[15:0];
    case (op)
      LB:      extract = {{24{b[7]}}, b};
      LBU:     extract = {24'h0, b};
      LH:      extract = {{16{h[15]}}, h};
      LHU:     extract = {16'h0, h};
      default: extract = word;
    endcase
  endfunction

  // Splice the store lane into the word just read; the bus has no byte enables.
  function automatic logic [DATA_WIDTH-1:0] merge(input logic [3:0] op,
                                                  input logic [DATA_WIDTH-1:0] word,
                                                  input logic [DATA_WIDTH-1:0] data,
                                                  input logic [1:0] lane);
    logic [4:0]            sh;
    logic [DATA_WIDTH-1:0] mask;
    if (op == SB) begin
      sh   = {lane, 3'b000};
      mask = 32'h0000_00FF << sh;
    end else begin
      sh   = {lane[1], 4'b0000};
      mask = 32'h0000_FFFF << sh;
    end
    merge = (word & ~mask) | ((data << sh) & mask);
  endfunction

  always_comb begin
    op_valid    = mem_op_i inside {LB, LH, LW, LBU, LHU, SB, SH, SW};
    op_misal    = ((mem_op_i inside {LH, LHU, SH}) && mem_addr_i[0]) ||
                  ((mem_op_i inside {LW, SW}) && (mem_addr_i[1:0] != 2'b00));
    op_q_load   = op_q inside {LB, LH, LW, LBU, LHU};
    timeout_hit = (TIMEOUT_CYCLES != 0) && (timer == TO_LAST);
  end

  assign stall_o = rst_n_i && ((state == S_IDLE && op_valid) || state == S_RD || state == S_WR);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= S_IDLE;
      op_q        <= MEM_NOP;
      lane_q      <= 2'b00;
      data_q      <= '0;
      timer       <= '0;
      reg_wdata_o <= '0;
      reg_we_o    <= 1'b0;
      misalign_o  <= 1'b0;
      bus_err_o   <= 1'b0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
    end else begin
      reg_we_o   <= 1'b0;
      misalign_o <= 1'b0;
      bus_err_o  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (op_valid) begin
            op_q   <= mem_op_i;
            lane_q <= mem_addr_i[1:0];
            data_q <= mem_data_i;
            timer  <= '0;
            if (op_misal) begin
              misalign_o <= 1'b1;
              state      <= S_ERR;
            end else begin
              bus_req_o  <= 1'b1;
              bus_addr_o <= {mem_addr_i[ADDR_WIDTH-1:2], 2'b00};
              if (mem_op_i == SW) begin
                bus_we_o    <= 1'b1;
                bus_wdata_o <= mem_data_i;
                state       <= S_WR;
              end else begin
                bus_we_o <= 1'b0;
                state    <= S_RD;
              end
            end
          end
        end
        S_RD: begin
          if (bus_ack_i) begin
            if (op_q_load) begin
              bus_req_o   <= 1'b0;
              reg_we_o    <= 1'b1;
              reg_wdata_o <= extract(op_q, bus_rdata_i, lane_q);
              state       <= S_DONE;
            end else begin
              bus_we_o    <= 1'b1;
              bus_wdata_o <= merge(op_q, bus_rdata_i, data_q, lane_q);
              timer       <= '0;
              state       <= S_WR;
            end
          end else if (timeout_hit) begin
            bus_req_o <= 1'b0;
            bus_err_o <= 1'b1;
            state     <= S_ERR;
          end else begin
            timer <= timer + 32'd1;
          end
        end
        S_WR: begin
          if (bus_ack_i) begin
            bus_req_o <= 1'b0;
            bus_we_o  <= 1'b0;
            state     <= S_DONE;
          end else if (timeout_hit) begin
            bus_req_o <= 1'b0;
            bus_we_o  <= 1'b0;
            bus_err_o <= 1'b1;
            state     <= S_ERR;
          end else begin
            timer <= timer + 32'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - randomized bench for lsu_ctrl against a byte-array memory model
module tb_lsu_ctrl;

  localparam logic [3:0] OP_NOP = 4'd0, OP_LB = 4'd1, OP_LH = 4'd2, OP_LW = 4'd3, OP_LBU = 4'd4,
                         OP_LHU = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7, OP_SW = 4'd8;
  localparam int UNLIMITED = 1 << 30;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [3:0]  mem_op_i;
  logic [31:0] mem_addr_i, mem_data_i;
  logic        stall_o, reg_we_o, misalign_o, bus_err_o, bus_req_o, bus_we_o, bus_ack_i;
  logic [31:0] reg_wdata_o, bus_addr_o, bus_wdata_o, bus_rdata_i;

  lsu_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i),
    .mem_data_i(mem_data_i), .stall_o(stall_o), .reg_wdata_o(reg_wdata_o), .reg_we_o(reg_we_o),
    .misalign_o(misalign_o), .bus_err_o(bus_err_o), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i),
    .bus_ack_i(bus_ack_i)
  );

  initial forever #5 clk_i = ~clk_i;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          ref_bytes[0:1023];
  logic [31:0] mem[0:255];
  int          ack_delay = 0;
  int          ack_limit = 0;
  int          ack_count, wait_cnt;

  // Bus slave: acks after ack_delay wait cycles, while the ack budget lasts.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    bus_ack_i = 1'b0; bus_rdata_i = 32'h0; wait_cnt = 0; ack_count = 0;
    forever begin
      @(negedge clk_i);
      bus_ack_i   = bus_req_o && (ack_count < ack_limit) && (wait_cnt >= ack_delay);
      bus_rdata_i = bus_ack_i ? mem[bus_addr_o[9:2]] : $urandom;
      @(posedge clk_i);
      if (bus_req_o && bus_ack_i) begin
        if (bus_we_o) mem[bus_addr_o[9:2]] = bus_wdata_o;
        ack_count++;
        wait_cnt = 0;
      end else if (bus_req_o) wait_cnt++;
      else wait_cnt = 0;
    end
  end

  function automatic int op_size(input logic [3:0] op);
    if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
    return 4;
  endfunction

  function automatic bit is_load(input logic [3:0] op);
    return op >= OP_LB && op <= OP_LHU;
  endfunction

  function automatic logic [31:0] ref_word(input int a);
    int b;
    b = a & ~3;
    return {8'(ref_bytes[b+3]), 8'(ref_bytes[b+2]), 8'(ref_bytes[b+1]), 8'(ref_bytes[b])};
  endfunction

  function automatic logic [31:0] ref_load(input logic [3:0] op, input int a);
    int v;
    case (op)
      OP_LB:  begin v = ref_bytes[a]; if (v > 127) v -= 256; end
      OP_LBU: v = ref_bytes[a];
      OP_LH:  begin v = ref_bytes[a] + 256 * ref_bytes[a+1]; if (v > 32767) v -= 65536; end
      OP_LHU: v = ref_bytes[a] + 256 * ref_bytes[a+1];
      default: return ref_word(a);
    endcase
    return 32'(v);
  endfunction

  task automatic ref_store(input logic [3:0] op, input int a, input logic [31:0] data);
    for (int i = 0; i < op_size(op); i++) ref_bytes[a+i] = int'((data >> (8 * i)) & 32'hFF);
  endtask

  int          obs_stalls, obs_reqs, obs_wr_cycles;
  logic [31:0] obs_req_addr, obs_wdata;
  bit          obs_we, obs_mis, obs_err, obs_early, obs_after;

  task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                        input int d);
    ack_delay = d;
    @(posedge clk_i); #1;
    mem_op_i = op; mem_addr_i = addr; mem_data_i = data;
    obs_stalls = 0; obs_reqs = 0; obs_wr_cycles = 0; obs_req_addr = 32'hFFFF_FFFF;
    obs_we = 0; obs_mis = 0; obs_err = 0; obs_early = 0; obs_wdata = 32'h0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk_i);
      if (bus_req_o) begin obs_reqs++; obs_req_addr = bus_addr_o; end
      if (bus_req_o && bus_we_o) obs_wr_cycles++;
      if (stall_o) begin
        obs_stalls++;
        if (reg_we_o || misalign_o || bus_err_o) obs_early = 1;
      end else begin
        obs_we = reg_we_o; obs_wdata = reg_wdata_o; obs_mis = misalign_o; obs_err = bus_err_o;
        break;
      end
    end
    @(posedge clk_i); #1;
    mem_op_i = OP_NOP;
    @(negedge clk_i);
    obs_after = reg_we_o || misalign_o || bus_err_o || stall_o || bus_req_o;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0; mem_op_i = OP_LW; mem_addr_i = 32'h100; mem_data_i = 32'h0;
    repeat (2) @(negedge clk_i);
    n_cmp++;
    if ({stall_o, bus_req_o, bus_we_o, reg_we_o, misalign_o, bus_err_o} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {stall_o, bus_req_o, bus_we_o, reg_we_o, misalign_o, bus_err_o});
    end
    n_cmp++;
    if ({reg_wdata_o, bus_addr_o, bus_wdata_o} !== 96'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h %h %h want 0", reg_wdata_o, bus_addr_o, bus_wdata_o);
    end
    mem_op_i = OP_NOP;
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
  endtask

  task automatic test_nop_idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      n_cmp++;
      if ({stall_o, bus_req_o} !== 2'b00) begin
        n_fail++;
        $display("FAIL nop_idle: got stall/req %b want 00", {stall_o, bus_req_o});
      end
    end
  endtask

  task automatic test_lw();
    run_op(OP_SW, 32'h100, 32'hDEADBEEF, 0);
    ref_store(OP_SW, 32'h100, 32'hDEADBEEF);
    n_cmp++;
    if (obs_stalls !== 2 || mem[32'h100 >> 2] !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL sw_basic: got stalls %0d mem %h want 2 deadbeef", obs_stalls, mem[64]);
    end
    run_op(OP_LW, 32'h100, 32'h0, 0);
    n_cmp++;
    if (obs_stalls !== 2) begin
      n_fail++; $display("FAIL lw_stall: got %0d want 2", obs_stalls);
    end
    n_cmp++;
    if (obs_we !== 1'b1 || obs_wdata !== 32'hDEADBEEF || obs_req_addr !== 32'h100) begin
      n_fail++;
      $display("FAIL lw_result: got we %b data %h addr %h want 1 deadbeef 00000100",
               obs_we, obs_wdata, obs_req_addr);
    end
    n_cmp++;
    if (obs_after !== 1'b0) begin
      n_fail++; $display("FAIL lw_pulse: got lingering outputs %b want 0", obs_after);
    end
  endtask

  task automatic test_lb_lbu();
    run_op(OP_SW, 32'h100, 32'h80FF1234, 1);
    ref_store(OP_SW, 32'h100, 32'h80FF1234);
    run_op(OP_LB, 32'h103, 32'h0, 0);
    n_cmp++;
    if (obs_wdata !== 32'hFFFFFF80 || obs_we !== 1'b1) begin
      n_fail++; $display("FAIL lb_sext: got %h we %b want ffffff80 1", obs_wdata, obs_we);
    end
    run_op(OP_LBU, 32'h103, 32'h0, 0);
    n_cmp++;
    if (obs_wdata !== 32'h00000080 || obs_we !== 1'b1) begin
      n_fail++; $display("FAIL lbu_zext: got %h we %b want 00000080 1", obs_wdata, obs_we);
    end
  endtask

  task automatic test_sb_rmw();
    run_op(OP_SW, 32'h200, 32'h11223344, 0);
    ref_store(OP_SW, 32'h200, 32'h11223344);
    run_op(OP_SB, 32'h202, 32'h000000AA, 0);
    ref_store(OP_SB, 32'h202, 32'h000000AA);
    n_cmp++;
    if (mem[32'h200 >> 2] !== 32'h11AA3344 || obs_req_addr !== 32'h200) begin
      n_fail++;
      $display("FAIL sb_merge: got mem %h addr %h want 11aa3344 00000200",
               mem[32'h200 >> 2], obs_req_addr);
    end
    n_cmp++;
    if (obs_stalls !== 3 || obs_we !== 1'b0 || obs_early !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_timing: got stalls %0d we %b early %b want 3 0 0",
               obs_stalls, obs_we, obs_early);
    end
  endtask

  task automatic test_misalign();
    run_op(OP_SH, 32'h301, 32'h0000BEEF, 0);
    n_cmp++;
    if (obs_stalls !== 1 || obs_reqs !== 0 || {obs_mis, obs_err, obs_we} !== 3'b100) begin
      n_fail++;
      $display("FAIL sh_misalign: got stalls %0d reqs %0d mis/err/we %b want 1 0 100",
               obs_stalls, obs_reqs, {obs_mis, obs_err, obs_we});
    end
    n_cmp++;
    if (obs_after !== 1'b0) begin
      n_fail++; $display("FAIL misalign_pulse: got lingering outputs %b want 0", obs_after);
    end
  endtask

  task automatic test_timeout();
    ack_limit = ack_count;
    run_op(OP_LW, 32'h100, 32'h0, 0);
    n_cmp++;
    if (obs_reqs !== 4 || obs_stalls !== 5 || {obs_err, obs_we, obs_mis} !== 3'b100) begin
      n_fail++;
      $display("FAIL lw_timeout: got reqs %0d stalls %0d err/we/mis %b want 4 5 100",
               obs_reqs, obs_stalls, {obs_err, obs_we, obs_mis});
    end
    n_cmp++;
    if (obs_after !== 1'b0) begin
      n_fail++; $display("FAIL timeout_pulse: got lingering outputs %b want 0", obs_after);
    end
    ack_limit = UNLIMITED;
    run_op(OP_SW, 32'h104, 32'hCAFEF00D, 0);
    ref_store(OP_SW, 32'h104, 32'hCAFEF00D);
    ack_limit = ack_count + 1;
    run_op(OP_SB, 32'h105, 32'h00000055, 0);
    n_cmp++;
    if (mem[32'h104 >> 2] !== 32'hCAFEF00D || obs_err !== 1'b1 || obs_reqs !== 5) begin
      n_fail++;
      $display("FAIL rmw_timeout: got mem %h err %b reqs %0d want cafef00d 1 5",
               mem[32'h104 >> 2], obs_err, obs_reqs);
    end
    ack_limit = UNLIMITED;
  endtask

  task automatic test_reset_mid_rd();
    logic [31:0] d;
    ack_limit = ack_count;
    @(posedge clk_i); #1;
    mem_op_i = OP_LW; mem_addr_i = 32'h104;
    repeat (2) @(negedge clk_i);
    n_cmp++;
    if (bus_req_o !== 1'b1) begin
      n_fail++; $display("FAIL mid_rd_req: got %b want 1", bus_req_o);
    end
    #2 rst_n_i = 1'b0;
    #1;
    n_cmp++;
    if ({bus_req_o, stall_o, reg_we_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL mid_rd_drop: got req/stall/we %b want 000", {bus_req_o, stall_o, reg_we_o});
    end
    mem_op_i = OP_NOP;
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    ack_limit = UNLIMITED;
    d = $urandom;
    run_op(OP_SW, 32'h10C, d, 1);
    ref_store(OP_SW, 32'h10C, d);
    n_cmp++;
    if (obs_stalls !== 3 || mem[32'h10C >> 2] !== d) begin
      n_fail++;
      $display("FAIL post_reset_sw: got stalls %0d mem %h want 3 %h",
               obs_stalls, mem[32'h10C >> 2], d);
    end
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [31:0] addr, data, exp;
    int          d, sz, phases;
    bit          mis, sub_store;
    for (int i = 0; i < 70; i++) begin
      op   = (i < 20) ? OP_SW : 4'($urandom_range(1, 8));
      sz   = op_size(op);
      addr = 32'($urandom_range(0, 127));
      if (i < 20 || $urandom_range(0, 3) != 0) addr = addr & ~32'(sz - 1);
      data = $urandom;
      d    = $urandom_range(0, 2);
      mis  = (addr % sz) != 0;
      sub_store = (op == OP_SB || op == OP_SH);
      phases = mis ? 0 : (sub_store ? 2 : 1);
      exp  = ref_load(op, int'(addr));
      run_op(op, addr, data, d);
      if (!mis && !is_load(op)) ref_store(op, int'(addr), data);
      n_cmp++;
      if (obs_stalls !== 1 + (d + 1) * phases || obs_reqs !== (d + 1) * phases) begin
        n_fail++;
        $display("FAIL rnd_timing[%0d]: op %0d got stalls %0d reqs %0d want %0d %0d", i, op,
                 obs_stalls, obs_reqs, 1 + (d + 1) * phases, (d + 1) * phases);
      end
      n_cmp++;
      if ({obs_we, obs_mis, obs_err, obs_early, obs_after} !== {is_load(op) && !mis, mis, 3'b000}) begin
        n_fail++;
        $display("FAIL rnd_flags[%0d]: op %0d addr %h got we/mis/err/early/after %b want %b", i,
                 op, addr, {obs_we, obs_mis, obs_err, obs_early, obs_after},
                 {is_load(op) && !mis, mis, 3'b000});
      end
      n_cmp++;
      if (obs_wr_cycles !== ((is_load(op) || mis) ? 0 : d + 1)) begin
        n_fail++;
        $display("FAIL rnd_writes[%0d]: op %0d got %0d write cycles want %0d", i, op,
                 obs_wr_cycles, (is_load(op) || mis) ? 0 : d + 1);
      end
      if (is_load(op) && !mis) begin
        n_cmp++;
        if (obs_wdata !== exp) begin
          n_fail++;
          $display("FAIL rnd_load[%0d]: op %0d addr %h got %h want %h", i, op, addr, obs_wdata, exp);
        end
      end
      n_cmp++;
      if (mem[addr[9:2]] !== ref_word(int'(addr))) begin
        n_fail++;
        $display("FAIL rnd_mem[%0d]: op %0d addr %h got %h want %h", i, op, addr,
                 mem[addr[9:2]], ref_word(int'(addr)));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ref_bytes[i] = 0;
    ack_limit = UNLIMITED;
    test_reset();
    test_nop_idle();
    test_lw();
    test_lb_lbu();
    test_sb_rmw();
    test_misalign();
    test_timeout();
    test_reset_mid_rd();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store sequencer between the S/L-type execute stage and a shared word-only data bus with no byte enables.
- Registers the execute stage's memory request and stalls the pipeline until the access completes.
- Performs sub-word stores as read-modify-write and sign- or zero-extends loads.
- Flags misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles in RD/WR waiting for bus_ack_i before an error is raised. 0 disables the timeout.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous, active-low reset
- mem_op_i  in  4  op from execute stage (`MEM_NOP, `LB, `LH, `LW, `LBU, `LHU, `SB, `SH, `SW from defines.v)
- mem_addr_i  in  `ADDR_WIDTH  byte address
- mem_data_i  in  `DATA_WIDTH  store data (low bits significant for SB/SH)
- stall_o  out  1  hold execute/decode inputs stable
- reg_wdata_o  out  `DATA_WIDTH  load result
- reg_we_o  out  1  load-result write strobe
- misalign_o  out  1  one-cycle misalignment pulse
- bus_err_o  out  1  one-cycle timeout pulse
- bus_req_o  out  1  bus request
- bus_we_o  out  1  1 = write, 0 = read
- bus_addr_o  out  `ADDR_WIDTH  word address, bits [1:0] = 0
- bus_wdata_o  out  `DATA_WIDTH  write word
- bus_rdata_i  in  `DATA_WIDTH  read word, valid with ack
- bus_ack_i  in  1  completes the current request

Behaviour:
- Reset (async, rst_n_i=0):
  - state=IDLE; all outputs 0.
  - Internal address, data, op and timeout registers cleared.
  - Asserting reset mid-access drops bus_req_o immediately; no reg or memory side effects follow.
- FSM states: IDLE, RD, WR, DONE, ERR.
- IDLE:
  - mem_op_i=`MEM_NOP: stay in IDLE, stall_o=0.
  - Any other op: stall_o=1 combinationally, and op, addr and data are latched.
  - Next state:
    - misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0): ERR.
    - SW: WR.
    - all loads, SB and SH: RD.
- RD:
  - bus_req_o=1, bus_we_o=0, bus_addr_o={addr[31:2],2'b00}.
  - On ack, latch bus_rdata_i.
  - Loads then go to DONE. SB/SH then go to WR with merged data:
    - SB replaces byte addr[1:0].
    - SH replaces halfword addr[1].
- WR:
  - bus_req_o=1, bus_we_o=1.
  - bus_wdata_o = merged word (SB/SH) or mem_data_i as latched (SW).
  - On ack go to DONE.
- Request rules:
  - bus_req_o stays high and addr/wdata stay stable until the ack cycle.
  - Ack may arrive in the first req cycle.
  - Ack outside RD/WR is ignored.
- DONE (one cycle):
  - stall_o=0.
  - Loads: reg_we_o=1, reg_wdata_o = extracted lane.
    - LB/LH: sign-extended.
    - LBU/LHU: zero-extended.
    - LW: full word.
  - Next state is IDLE. The op still present on inputs in this cycle is not re-accepted.
- ERR (one cycle):
  - stall_o=0; misalign_o or bus_err_o = 1.
  - reg_we_o=0; no bus write has occurred for the failing access.
  - Next state is IDLE.
- Timeout:
  - Counter clears on entry to RD/WR and increments each non-ack cycle.
  - If it reaches TIMEOUT_CYCLES, bus_req_o drops and the FSM goes to ERR with bus_err_o.
  - A partially completed RMW (read done, write timed out) leaves memory unchanged.
- Latency with ack in the first req cycle:
  - Loads and SW: stall high 2 cycles; result or completion in cycle 3.
  - SB/SH: stall high 3 cycles.
- reg_wdata_o holds its last value outside DONE; reg_we_o is a strict one-cycle pulse.

Test Plan:
- LW: addr 0x100, bus_rdata 0xDEADBEEF, ack in the first req cycle -> stall_o high 2 cycles; DONE has reg_we_o=1, reg_wdata_o=0xDEADBEEF; bus_addr_o=0x100.
- LB/LBU: addr 0x103, rdata 0x80FF1234 -> LB gives 0xFFFFFF80; LBU gives 0x00000080.
- SB RMW: addr 0x202, data 0x000000AA, read returns 0x11223344 -> write at 0x200 with 0x11AA3344; stall high 3 cycles; reg_we_o never set.
- SH misaligned: addr 0x301 -> ERR, misalign_o one pulse, bus_req_o never asserted.
- Timeout, TIMEOUT_CYCLES=4, LW with no ack -> bus_req_o high 4 cycles, then bus_err_o pulse, reg_we_o=0.
- Reset mid-RD: rst_n_i=0 while bus_req_o=1 -> bus_req_o and stall_o drop immediately; after release, state=IDLE and the next SW completes normally.
